// File: rtl/mem_latency_responder_pkg.sv
// Shared constants and pipeline bundle for the memory responder
// and the cache fill FSM that talks to it.
package mem_latency_responder_pkg;

    localparam int WORD_W          = 16;
    localparam int ADDR_W          = 16;
    localparam int DEF_LATENCY     = 4;
    localparam int DEF_DEPTH_WORDS = 32768;
    localparam int BLOCK_BYTES     = 16;
    localparam int WORDS_PER_BLOCK = BLOCK_BYTES / (WORD_W / 8);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } stage_t;

    // Clears the byte-select bit so every address names a whole word.
    function automatic logic [ADDR_W-1:0] word_align(
        input logic [ADDR_W-1:0] a
    );
        return a & ~ADDR_W'(1);
    endfunction

endpackage

// File: rtl/mem_latency_responder_if.sv
// Request/response bus between the cache fill FSM (master)
// and the memory responder (slave).
interface mem_latency_responder_if;
    import mem_latency_responder_pkg::*;

    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data_in;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic [ADDR_W-1:0] addr_out;
    logic              busy;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, addr_out, busy
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, addr_out, busy
    );

endinterface

// File: rtl/mem_latency_responder_stage.sv
// One delay stage of the read-return pipeline.
// Payload only moves with a valid beat, so it holds across bubbles.
module mem_pipe_stage
    import mem_latency_responder_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  stage_t d,
    output stage_t q
);

    // Shift valid every cycle; capture payload only for real reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q.valid <= d.valid;
            if (d.valid) begin
                q.addr <= d.addr;
                q.data <= d.data;
            end
        end
    end

endmodule

// File: rtl/mem_latency_responder.sv
// Word-array memory model with a fixed read latency.
// Reads sample the array at issue; writes land in one cycle.
module mem_latency_responder
    import mem_latency_responder_pkg::*;
#(
    parameter int LATENCY     = DEF_LATENCY,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_latency_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [WORD_W-1:0]        mem [DEPTH_WORDS];
    logic [ADDR_W-1:0]        aligned;
    logic [IDX_W-1:0]         idx;
    logic                     rd_req;
    logic                     wr_req;
    logic                     busy_c;
    stage_t                   req;
    stage_t [LATENCY-1:0]     pipe;

    // Decode the request and form the stage-0 bundle.
    always_comb begin
        aligned = word_align(bus.addr);
        idx     = IDX_W'((32'(bus.addr) >> 1) % DEPTH_WORDS);
        rd_req  = bus.enable & ~bus.wr;
        wr_req  = bus.enable & bus.wr;
        req     = '{valid: rd_req, addr: aligned, data: mem[idx]};
    end

    // Write-through store; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_req) begin
            mem[idx] <= bus.data_in;
        end
    end

    mem_pipe_stage u_stage0 (
        .clk (clk),
        .rst (rst),
        .d   (req),
        .q   (pipe[0])
    );

    for (genvar i = 1; i < LATENCY; i++) begin : g_stage
        mem_pipe_stage u_stage (
            .clk (clk),
            .rst (rst),
            .d   (pipe[i-1]),
            .q   (pipe[i])
        );
    end

    // Any valid stage means a read is still in flight.
    always_comb begin
        busy_c = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy_c = busy_c | pipe[i].valid;
        end
    end

    assign bus.data_valid = pipe[LATENCY-1].valid;
    assign bus.data_out   = pipe[LATENCY-1].data;
    assign bus.addr_out   = pipe[LATENCY-1].addr;
    assign bus.busy       = busy_c;

endmodule

// File: tb/tb_mem_latency_responder.sv
// Bench for mem_latency_responder: vector table plus
// a scoreboard of reads due back LATENCY cycles later.
module tb_mem_latency_responder;

    localparam int L = 4;

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
        logic [15:0] data;
    } sb_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    logic [15:0] last_d;
    logic [15:0] last_a;

    vec_t vecs[$];
    sb_t  sb[$];

    mem_latency_responder_if bus ();

    mem_latency_responder #(
        .LATENCY     (L),
        .DEPTH_WORDS (32768)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       name,
        input logic [15:0] act,
        input logic [15:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic add(
        input logic        en,
        input logic        wr,
        input logic [15:0] a,
        input logic [15:0] d,
        input logic [15:0] x
    );
        vec_t v;
        v.en   = en;
        v.wr   = wr;
        v.addr = a;
        v.din  = d;
        v.exp  = x;
        vecs.push_back(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 16'h0, 16'h0, 16'h0);
    endtask

    // One cycle: check outputs after the edge, then drive.
    task automatic step(input vec_t v);
        logic exp_v;
        logic exp_b;
        sb_t  e;
        @(posedge clk);
        #1;
        cyc++;
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        chk("valid", 16'(bus.data_valid), 16'(exp_v));
        if (exp_v) begin
            e = sb.pop_front();
            chk("data", bus.data_out, e.data);
            chk("addr", bus.addr_out, e.addr);
            last_d = e.data;
            last_a = e.addr;
        end else begin
            chk("hold_data", bus.data_out, last_d);
            chk("hold_addr", bus.addr_out, last_a);
        end
        exp_b = exp_v || (sb.size() > 0);
        chk("busy", 16'(bus.busy), 16'(exp_b));
        bus.enable  = v.en;
        bus.wr      = v.wr;
        bus.addr    = v.addr;
        bus.data_in = v.din;
        if (v.en && !v.wr) begin
            e.due  = cyc + L;
            e.addr = v.addr & 16'hFFFE;
            e.data = v.exp;
            sb.push_back(e);
        end
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        last_d      = 16'h0;
        last_a      = 16'h0;
        rst         = 1'b0;
        bus.enable  = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = 16'h0;
        bus.data_in = 16'h0;

        #12;
        chk("rst_valid", 16'(bus.data_valid), 16'h0);
        chk("rst_data", bus.data_out, 16'h0);
        chk("rst_addr", bus.addr_out, 16'h0);
        chk("rst_busy", 16'(bus.busy), 16'h0);
        #10;
        rst = 1'b1;

        // Preload the words used below.
        for (int i = 0; i < 8; i++)
            add(1, 1, 16'h0010 + 16'(2 * i),
                16'hA000 + 16'(i), 16'h0);
        add(1, 1, 16'h0080, 16'h5555, 16'h0);
        add(1, 1, 16'hFFFE, 16'h7E7E, 16'h0);
        idle(1);

        // Eight back-to-back reads of a block.
        for (int i = 0; i < 8; i++)
            add(1, 0, 16'h0010 + 16'(2 * i),
                16'h0, 16'hA000 + 16'(i));
        idle(5);

        // Write then read with bit 0 set.
        add(1, 1, 16'h0040, 16'h1234, 16'h0);
        add(1, 0, 16'h0041, 16'h0, 16'h1234);
        idle(5);

        // Read in flight sees old value; later read sees new.
        add(1, 0, 16'h0080, 16'h0, 16'h5555);
        add(1, 1, 16'h0080, 16'hBEEF, 16'h0);
        add(1, 0, 16'h0080, 16'h0, 16'hBEEF);
        idle(5);

        // Gapped reads keep their gaps.
        add(1, 0, 16'h0010, 16'h0, 16'hA000);
        idle(1);
        add(1, 0, 16'h0012, 16'h0, 16'hA001);
        add(1, 0, 16'h0014, 16'h0, 16'hA002);
        idle(5);

        // Top of the array.
        add(1, 0, 16'hFFFF, 16'h0, 16'h7E7E);
        idle(5);

        // Three reads to be killed by reset.
        add(1, 0, 16'h0016, 16'h0, 16'hA003);
        add(1, 0, 16'h0018, 16'h0, 16'hA004);
        add(1, 0, 16'h001A, 16'h0, 16'hA005);
        run_vecs();

        @(posedge clk);
        #2;
        bus.enable = 1'b0;
        chk("pre_rst_busy", 16'(bus.busy), 16'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(bus.data_valid), 16'h0);
        chk("mid_rst_busy", 16'(bus.busy), 16'h0);
        chk("mid_rst_data", bus.data_out, 16'h0);
        sb.delete();
        cyc++;
        last_d = 16'h0;
        last_a = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc++;

        // Nothing returns; array content survived reset.
        idle(6);
        add(1, 0, 16'h0040, 16'h0, 16'h1234);
        idle(6);
        run_vecs();

        chk("sb_empty", 16'(sb.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
